// File: rtl/cplx_addsub_pipe.sv
// Two-stage complex add/sub on packed {re, im} signed parts.
// Stage 1 holds operands; stage 2 holds the result, its overflow flags and the accumulator.
module cplx_addsub_pipe #(
  parameter int PART_LEN = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*PART_LEN-1:0] a,
  input  logic [2*PART_LEN-1:0] b,
  input  logic [1:0]            op,
  input  logic                  sat,
  input  logic                  acc_clr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*PART_LEN-1:0] res,
  output logic [1:0]            ovf
);

  localparam int W  = 2 * PART_LEN;
  localparam int EW = PART_LEN + 1;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_CONJ = 2'b10;
  localparam logic [1:0] OP_ACC  = 2'b11;

  typedef logic [PART_LEN-1:0] part_t;
  typedef logic [EW-1:0]       ext_t;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    logic         sat;
    logic         clr;
  } s1_t;

  function automatic ext_t ext_addsub(part_t x, part_t y, logic sub);
    ext_t xe;
    ext_t ye;
    xe = {x[PART_LEN-1], x};
    ye = {y[PART_LEN-1], y};
    return sub ? (xe - ye) : (xe + ye);
  endfunction

  function automatic logic part_ovf(ext_t e);
    return e[EW-1] ^ e[EW-2];
  endfunction

  // The sign of the exact sum picks the rail: 100..0 or 011..1
  function automatic part_t clamp(ext_t e, logic sat_on);
    part_t lim;
    lim = {e[EW-1], {(PART_LEN-1){~e[EW-1]}}};
    return (sat_on && part_ovf(e)) ? lim : e[PART_LEN-1:0];
  endfunction

  s1_t          s1_q;
  logic         s1_valid;
  logic         s2_valid;
  logic         s2_free;
  logic         s1_adv;
  logic         accept;
  logic [W-1:0] acc_q;
  logic [W-1:0] res_q;
  logic [1:0]   ovf_q;

  part_t        x_re;
  part_t        x_im;
  part_t        y_re;
  part_t        y_im;
  part_t        base_re;
  part_t        base_im;
  logic         re_sub;
  logic         im_sub;
  logic         use_acc;
  ext_t         e_re;
  ext_t         e_im;
  logic [W-1:0] nres;
  logic [1:0]   novf;

  assign s2_free  = !s2_valid || out_ready;
  assign s1_adv   = s1_valid && s2_free;
  assign in_ready = !s1_valid || s2_free;
  assign accept   = in_valid && in_ready;

  always_comb begin
    re_sub  = 1'b0;
    im_sub  = 1'b0;
    use_acc = 1'b0;
    unique case (s1_q.op)
      OP_ADD: ;
      OP_SUB: begin
        re_sub = 1'b1;
        im_sub = 1'b1;
      end
      OP_CONJ: im_sub = 1'b1;
      OP_ACC:  use_acc = 1'b1;
      default: ;
    endcase
  end

  assign base_re = s1_q.clr ? '0 : acc_q[W-1:PART_LEN];
  assign base_im = s1_q.clr ? '0 : acc_q[PART_LEN-1:0];

  assign x_re = use_acc ? base_re : s1_q.a[W-1:PART_LEN];
  assign x_im = use_acc ? base_im : s1_q.a[PART_LEN-1:0];
  assign y_re = s1_q.b[W-1:PART_LEN];
  assign y_im = s1_q.b[PART_LEN-1:0];

  assign e_re = ext_addsub(x_re, y_re, re_sub);
  assign e_im = ext_addsub(x_im, y_im, im_sub);

  assign nres = {clamp(e_re, s1_q.sat), clamp(e_im, s1_q.sat)};
  assign novf = {part_ovf(e_re), part_ovf(e_im)};

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_q <= '{a: a, b: b, op: op, sat: sat, clr: acc_clr};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      acc_q    <= '0;
      res_q    <= '0;
      ovf_q    <= '0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
      end
      if (s2_free) begin
        s2_valid <= s1_valid;
      end
      if (s1_adv) begin
        res_q <= nres;
        ovf_q <= novf;
      end
      // Next op=11 in stage 1 sees this value immediately, no bubble
      if (s1_adv && use_acc) begin
        acc_q <= nres;
      end else if (s1_adv && s1_q.clr) begin
        acc_q <= '0;
      end
    end
  end

  assign out_valid = s2_valid;
  assign res       = res_q;
  assign ovf       = ovf_q;

endmodule
